// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ valid/ready producers share one FIFO write port,
// one owner at a time for up to MAX_BURST beats, then the pointer rotates past the owner.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          grant,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_wdata
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] LAST_REQ   = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [PTR_W-1:0]   g_r, g_s;
  logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && v[idx]) begin
        pick  = idx[PTR_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    return (i == LAST_REQ) ? '0 : i + 1'b1;
  endfunction

  // State register; reset_n is active-high despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_r  <= ST_IDLE;
      g_r      <= '0;
      rr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_s;
      g_r      <= g_s;
      rr_ptr_r <= rr_ptr_s;
      cnt_r    <= cnt_s;
    end
  end

  // Next-state: arbitration in IDLE, beat counting and release in BURST.
  always_comb begin
    state_s  = state_r;
    g_s      = g_r;
    rr_ptr_s = rr_ptr_r;
    cnt_s    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_s = ST_BURST;
          g_s     = rr_pick(req_valid, rr_ptr_r);
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (!req_valid[g_r]) begin
          state_s  = ST_IDLE;
          rr_ptr_s = next_idx(g_r);
        end else if (!fifo_full) begin
          if (cnt_r == LAST_BEAT) begin
            state_s  = ST_IDLE;
            rr_ptr_s = next_idx(g_r);
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs: grant from registered owner, write path combinational through the owner's slice.
  always_comb begin
    grant      = '0;
    req_ready  = '0;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    case (state_r)
      ST_BURST: begin
        grant      = ONE_HOT0 << g_r;
        req_ready  = fifo_full ? '0 : (ONE_HOT0 << g_r);
        fifo_wr    = req_valid[g_r] & ~fifo_full;
        fifo_wdata = req_data[int'(g_r)*DATA_W +: DATA_W];
      end
      ST_IDLE: begin
        grant = '0;
      end
      default: begin
        grant = '0;
      end
    endcase
  end

endmodule
